// File: rtl/vc_pin_bus.sv
// vc_pin_bus: pin-multiplexed external bus master for the vc CPU tile.
// Serialises one address/data request over a PW-bit pin group, MSB beat first.
module vc_pin_bus #(
    parameter int PA   = 24,
    parameter int DW   = 16,
    parameter int PW   = 8,
    parameter int TURN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wr,
    input  logic [PA-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    input  logic [PW-1:0] pin_in,
    output logic [PW-1:0] pin_out,
    output logic [PW-1:0] pin_oe,
    output logic          strobe,
    output logic          bus_wr,
    input  logic          ext_rdy
);

    localparam int NA = (PA + PW - 1) / PW;
    localparam int NW = (DW + PW - 1) / PW;
    localparam int AW = NA * PW;
    localparam int WW = NW * PW;
    localparam int MNW = (NA > NW) ? NA : NW;
    localparam int MAXC = (MNW > TURN) ? MNW : TURN;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] A_LAST = CW'(NA - 1);
    localparam logic [CW-1:0] W_LAST = CW'(NW - 1);
    localparam logic [CW-1:0] T_LAST = CW'(TURN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_TURN,
        S_RDATA,
        S_DONE
    } state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic          wr_q, nwr;
    logic [AW-1:0] ash, nash;
    logic [WW-1:0] wsh, nwsh;
    logic [WW-1:0] rsh, nrsh;
    logic [PW-1:0] npin;
    logic          oe_q, noe;
    logic          nstb;
    logic          nbwr;
    logic          nack;
    logic [DW-1:0] nrdata;

    logic [AW-1:0] addr_ext;
    logic [WW-1:0] data_ext;
    logic [WW-1:0] in_ext;
    logic [WW-1:0] rshift;

    // Zero-extend at the MSB end so the first beat carries the padding.
    always_comb begin
        addr_ext = '0;
        addr_ext[PA-1:0] = addr;
        data_ext = '0;
        data_ext[DW-1:0] = wdata;
        in_ext = '0;
        in_ext[PW-1:0] = pin_in;
        rshift = (rsh << PW) | in_ext;
    end

    assign pin_oe = {PW{oe_q}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            ash     <= '0;
            wsh     <= '0;
            rsh     <= '0;
            pin_out <= '0;
            oe_q    <= 1'b0;
            strobe  <= 1'b0;
            bus_wr  <= 1'b0;
            ack     <= 1'b0;
            rdata   <= '0;
        end else begin
            state   <= nstate;
            cnt     <= ncnt;
            wr_q    <= nwr;
            ash     <= nash;
            wsh     <= nwsh;
            rsh     <= nrsh;
            pin_out <= npin;
            oe_q    <= noe;
            strobe  <= nstb;
            bus_wr  <= nbwr;
            ack     <= nack;
            rdata   <= nrdata;
        end
    end

    // Outputs are computed for the next state so they appear registered.
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        nwr    = wr_q;
        nash   = ash;
        nwsh   = wsh;
        nrsh   = rsh;
        npin   = '0;
        noe    = 1'b0;
        nstb   = 1'b0;
        nbwr   = 1'b0;
        nack   = 1'b0;
        nrdata = rdata;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    nstate = S_ADDR;
                    ncnt   = '0;
                    nwr    = wr;
                    nash   = addr_ext << PW;
                    nwsh   = data_ext;
                    npin   = addr_ext[AW-1 -: PW];
                    noe    = 1'b1;
                    nstb   = 1'b1;
                    nbwr   = wr;
                end
            end
            S_ADDR: begin
                noe  = 1'b1;
                nbwr = wr_q;
                if (cnt != A_LAST) begin
                    ncnt = cnt + 1'b1;
                    npin = ash[AW-1 -: PW];
                    nash = ash << PW;
                end else begin
                    ncnt = '0;
                    if (wr_q) begin
                        nstate = S_WDATA;
                        npin   = wsh[WW-1 -: PW];
                        nwsh   = wsh << PW;
                    end else begin
                        nstate = S_TURN;
                        noe    = 1'b0;
                        nbwr   = 1'b0;
                    end
                end
            end
            S_WDATA: begin
                noe  = 1'b1;
                nbwr = 1'b1;
                npin = pin_out;
                if (ext_rdy) begin
                    if (cnt != W_LAST) begin
                        ncnt = cnt + 1'b1;
                        npin = wsh[WW-1 -: PW];
                        nwsh = wsh << PW;
                    end else begin
                        nstate = S_DONE;
                        ncnt   = '0;
                        noe    = 1'b0;
                        nbwr   = 1'b0;
                        npin   = '0;
                        nack   = 1'b1;
                    end
                end
            end
            S_TURN: begin
                if (cnt == T_LAST) begin
                    nstate = S_RDATA;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + 1'b1;
                end
            end
            S_RDATA: begin
                if (ext_rdy) begin
                    nrsh = rshift;
                    if (cnt == W_LAST) begin
                        nstate = S_DONE;
                        ncnt   = '0;
                        nack   = 1'b1;
                        nrdata = rshift[DW-1:0];
                    end else begin
                        ncnt = cnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                nstate = S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

endmodule
